// File: rtl/pg_pkg.sv
// Shared types and default sizing for the pattern-generator sequencer.
package pg_pkg;

   typedef enum logic {
      PG_IDLE = 1'b0,
      PG_PLAY = 1'b1
   } pg_state_t;

   localparam int PG_DEPTH  = 8;
   localparam int PG_WIDTH  = 8;
   localparam int PG_HOLD_W = 8;

endpackage

// File: rtl/pg_pattern_mem.sv
// Pattern store: one synchronous write port, one asynchronous read port, no reset.
module pg_pattern_mem
   import pg_pkg::*;
#(
   parameter int DEPTH = PG_DEPTH,
   parameter int WIDTH = PG_WIDTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pg_sequencer.sv
// Pattern sequencer: loads up to DEPTH words, then plays them out with a
// programmable per-word hold, once or looping until stopped.
module pg_sequencer
   import pg_pkg::*;
#(
   parameter int DEPTH  = PG_DEPTH,
   parameter int WIDTH  = PG_WIDTH,
   parameter int HOLD_W = PG_HOLD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic                       clear,
   input  logic                       wr_valid,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       wr_ready,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       loop,
   input  logic [HOLD_W-1:0]          hold_cycles,
   output logic [WIDTH-1:0]           pat_out,
   output logic                       pat_valid,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   pg_state_t         state;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_addr;
   logic [HOLD_W-1:0] hold_reg;
   logic [HOLD_W-1:0] hold_ctr;
   logic [WIDTH-1:0]  rd_data;
   logic              wr_fire;
   logic              at_last;
   logic              start_ok;

   // Write handshake: a word transfers when wr_valid && wr_ready; clear drops it.
   assign wr_ready = ena && (state == PG_IDLE) && (count < CW'(DEPTH));
   assign wr_fire  = wr_valid && wr_ready && !clear;
   assign at_last  = (CW'(rd_ptr) == count - CW'(1));
   assign start_ok = start && !stop && !clear && (count != '0);
   assign busy     = (state == PG_PLAY);

   // The read port always looks at the word to show next, so pat_out can be registered.
   assign rd_addr = (state == PG_PLAY && !at_last) ? rd_ptr + AW'(1) : '0;

   pg_pattern_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (count[AW-1:0]),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PG_IDLE;
         count     <= '0;
         rd_ptr    <= '0;
         hold_reg  <= '0;
         hold_ctr  <= '0;
         pat_out   <= '0;
         pat_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         // done is a single-cycle pulse even when ena drops right after it.
         done <= 1'b0;
         if (ena) begin
            case (state)
               PG_IDLE: begin
                  if (clear)        count <= '0;
                  else if (wr_fire) count <= count + CW'(1);
                  if (start_ok) begin
                     state     <= PG_PLAY;
                     hold_reg  <= hold_cycles;
                     hold_ctr  <= hold_cycles;
                     rd_ptr    <= '0;
                     pat_out   <= rd_data;
                     pat_valid <= 1'b1;
                  end
               end
               PG_PLAY: begin
                  if (stop) begin
                     state     <= PG_IDLE;
                     pat_out   <= '0;
                     pat_valid <= 1'b0;
                  end else if (hold_ctr != '0) begin
                     hold_ctr <= hold_ctr - HOLD_W'(1);
                  end else begin
                     hold_ctr <= hold_reg;
                     if (at_last && !loop) begin
                        state     <= PG_IDLE;
                        pat_out   <= '0;
                        pat_valid <= 1'b0;
                        done      <= 1'b1;
                     end else begin
                        rd_ptr  <= rd_addr;
                        pat_out <= rd_data;
                     end
                  end
               end
               default: state <= PG_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pg_sequencer.sv
// Self-checking bench for pg_sequencer: directed scenarios plus randomized runs
// checked against a stream model built from the loaded words and hold count.
module tb_pg_sequencer;

   localparam int DEPTH  = 8;
   localparam int WIDTH  = 8;
   localparam int HOLD_W = 8;
   localparam int CW     = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst;
   logic              ena;
   logic              clear;
   logic              wr_valid;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_ready;
   logic              start;
   logic              stop;
   logic              loop;
   logic [HOLD_W-1:0] hold_cycles;
   logic [WIDTH-1:0]  pat_out;
   logic              pat_valid;
   logic              busy;
   logic              done;
   logic [CW-1:0]     count;

   logic [WIDTH-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   pg_sequencer #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .HOLD_W (HOLD_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .clear       (clear),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .start       (start),
      .stop        (stop),
      .loop        (loop),
      .hold_cycles (hold_cycles),
      .pat_out     (pat_out),
      .pat_valid   (pat_valid),
      .busy        (busy),
      .done        (done),
      .count       (count)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag, input bit exp_done);
      check_eq({tag, "_valid"}, 32'(pat_valid), 32'd0);
      check_eq({tag, "_out"}, 32'(pat_out), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
   endtask

   // driver tasks: entered and left just after a negedge
   task automatic load_word(input logic [WIDTH-1:0] d);
      bit exp_rdy;
      exp_rdy = (exp_q.size() < DEPTH);
      check_eq("wr_ready", 32'(wr_ready), 32'(exp_rdy));
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
      if (exp_rdy) exp_q.push_back(d);
      check_eq("count_load", 32'(count), 32'(exp_q.size()));
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      exp_q.delete();
      check_eq("count_clear", 32'(count), 32'd0);
   endtask

   // Plays the stored pattern. Cycle k of playback must show word (k/(hold+1)) mod n.
   // stop_after < 0: run to natural completion; else stop while showing cycle stop_after-1.
   // freeze_at >= 0: drop ena for 4 cycles after observing that cycle.
   task automatic play_check(input int hold, input bit loop_v, input int stop_after,
                             input int freeze_at);
      int  n;
      int  per;
      int  obs_n;
      bit  natural;
      logic [WIDTH-1:0] w;
      n       = exp_q.size();
      per     = hold + 1;
      natural = (stop_after < 0);
      obs_n   = natural ? n * per : stop_after;
      hold_cycles = HOLD_W'(hold);
      loop  = loop_v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hold_cycles = HOLD_W'($urandom_range(0, 255));
      for (int k = 0; k < obs_n; k++) begin
         w = exp_q[(k / per) % n];
         check_eq("play_valid", 32'(pat_valid), 32'd1);
         check_eq("play_out", 32'(pat_out), 32'(w));
         check_eq("play_busy", 32'(busy), 32'd1);
         check_eq("play_done", 32'(done), 32'd0);
         check_eq("play_wr_ready", 32'(wr_ready), 32'd0);
         if (k == freeze_at) begin
            ena = 1'b0;
            for (int f = 0; f < 4; f++) begin
               @(negedge clk);
               check_eq("freeze_out", 32'(pat_out), 32'(w));
               check_eq("freeze_valid", 32'(pat_valid), 32'd1);
               check_eq("freeze_wr_ready", 32'(wr_ready), 32'd0);
            end
            ena = 1'b1;
         end
         if (!natural && k == obs_n - 1) stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
      end
      check_idle("end", natural);
      @(negedge clk);
      check_eq("done_pulse", 32'(done), 32'd0);
      check_eq("count_after", 32'(count), 32'(exp_q.size()));
   endtask

   initial begin
      int n;
      int hold;
      int total;
      int stop_after;
      bit lp;

      rst = 1'b1; ena = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0;
      start = 1'b0; stop = 1'b0; loop = 1'b0; hold_cycles = '0;
      repeat (3) @(negedge clk);
      check_idle("reset", 1'b0);
      check_eq("reset_count", 32'(count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // three words, no hold, single shot
      load_word(8'h11); load_word(8'h22); load_word(8'h33);
      play_check(0, 1'b0, -1, -1);

      // two words held three cycles each
      do_clear();
      load_word(8'hA5); load_word(8'h5A);
      play_check(2, 1'b0, -1, -1);

      // looping, stopped after five cycles
      do_clear();
      load_word(8'h01); load_word(8'h02);
      play_check(0, 1'b1, 5, -1);

      // fill beyond capacity; ninth word must be refused
      do_clear();
      for (int i = 0; i < 9; i++) load_word(WIDTH'(8'hC0 + i));
      check_eq("full_count", 32'(count), 32'(DEPTH));
      play_check(0, 1'b0, -1, -1);

      // clear wins over a simultaneous write
      clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
      @(negedge clk);
      clear = 1'b0; wr_valid = 1'b0;
      exp_q.delete();
      check_eq("clear_wins", 32'(count), 32'd0);

      // start with nothing loaded
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_idle("start_empty", 1'b0);

      // start and stop together
      load_word(8'h44);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check_idle("start_stop", 1'b0);
      // stop alone in IDLE is ignored and start still works
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check_eq("stop_idle_count", 32'(count), 32'd1);
      play_check(1, 1'b0, -1, -1);

      // asynchronous reset mid-playback
      do_clear();
      load_word(8'h10); load_word(8'h20); load_word(8'h30);
      hold_cycles = 8'd3; loop = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("pre_reset_valid", 32'(pat_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_idle("async_reset", 1'b0);
      check_eq("async_reset_count", 32'(count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);

      // clock enable dropped mid-word
      load_word(8'h5C); load_word(8'hC5);
      play_check(1, 1'b0, -1, 0);

      // randomized runs
      for (int r = 0; r < 25; r++) begin
         do_clear();
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) load_word(WIDTH'($urandom_range(0, 255)));
         hold  = $urandom_range(0, 3);
         lp    = 1'($urandom_range(0, 1));
         total = n * (hold + 1);
         if (lp)
            stop_after = $urandom_range(1, 2 * total + 1);
         else if (total > 1 && $urandom_range(0, 1) == 1)
            stop_after = $urandom_range(1, total - 1);
         else
            stop_after = -1;
         play_check(hold, lp, stop_after, ($urandom_range(0, 3) == 0) ? 0 : -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pg_sequencer.md
# pg_sequencer

Pattern sequencer core for the pattern-generator tile; it sits directly upstream of the tile's dedicated output pins. Software loads up to DEPTH pattern words through a valid/ready write port. On start, the sequencer plays the words out in order, holding each for a programmable number of cycles. Playback runs once or loops until stopped.

## Interface
Parameters:
- DEPTH, 8, number of pattern entries (power of two, ≥2)
- WIDTH, 8, pattern word width
- HOLD_W, 8, width of hold-cycle count

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ena  in  1  clock enable; 0 freezes every register
- clear  in  1  empty pattern store (IDLE only)
- wr_valid  in  1  write request
- wr_data  in  WIDTH  pattern word to append
- wr_ready  out  1  store accepts a word this cycle
- start  in  1  begin playback (IDLE only)
- stop  in  1  abort playback
- loop  in  1  1 = wrap to entry 0 after the last entry
- hold_cycles  in  HOLD_W  extra cycles each word is held
- pat_out  out  WIDTH  current pattern word
- pat_valid  out  1  pat_out is a live pattern
- busy  out  1  state is PLAY
- done  out  1  one-cycle pulse on natural completion
- count  out  $clog2(DEPTH+1)  number of loaded entries

## Operation
- States: IDLE, PLAY.
- Reset values: IDLE, count=0, pat_out=0, pat_valid=0, busy=0, done=0. Memory contents are not reset.
- Load:
  - wr_ready = ena && IDLE && count<DEPTH.
  - On wr_valid&&wr_ready, mem[count]<=wr_data and count++.
  - Writes while in PLAY or while full are not accepted; count is unchanged.
- Clear: in IDLE, clear sets count<=0. If clear and wr_valid are asserted together, clear wins and the write is dropped. clear is ignored in PLAY.
- Start (IDLE, count>0):
  - Latch hold_cycles into hold_reg, rd_ptr<=0, hold_ctr<=hold_reg.
  - Next state is PLAY.
  - start with count==0 is ignored, with no done pulse.
- PLAY:
  - pat_out=mem[rd_ptr], pat_valid=1.
  - hold_ctr decrements each cycle. When hold_ctr==0, advance: rd_ptr++ and reload hold_ctr.
  - At the last entry (rd_ptr==count-1) with hold_ctr==0:
    - loop=1: rd_ptr<=0.
    - loop=0: go to IDLE, pat_out<=0, pat_valid<=0, done=1 for one cycle.
  - loop is sampled live at each wrap decision.
- Stop: in PLAY, the next state is IDLE with pat_out=0 and pat_valid=0, and no done pulse. In IDLE, stop is ignored. If stop and start are asserted together in IDLE, start is ignored.
- ena=0: all state, counters and outputs hold. wr_ready=0. done is held low after one cycle; the pulse is never stretched.

## Timing
- wr_ready is combinational from state, count and ena. All other outputs are registered.
- Start accepted at cycle t: busy=1 and pat_valid=1 with pat_out=mem[0] at t+1.
- Each word is held hold_reg+1 cycles.
- Non-loop run: pat_valid is high for count*(hold_reg+1) cycles. done=1 in the first cycle after the last valid cycle, coincident with pat_valid=0 and busy=0.
- Loop run: no bubble at the wrap. mem[0] follows the last entry on the next cycle.
- Stop asserted at cycle t in PLAY: pat_valid=0 at t+1. A new start is accepted from t+1.
- Reset asserted mid-PLAY: outputs go to reset values immediately and asynchronously. count returns to 0, so the pattern store must be reloaded.

## Structure
- Shared package pg_pkg holds:
  - state enum (PG_IDLE, PG_PLAY)
  - default DEPTH/WIDTH/HOLD_W localparams
- Sub-module pg_pattern_mem: DEPTH×WIDTH register file with one synchronous write port and one asynchronous read port, no reset.
- The FSM, counters and output registers live in pg_sequencer.

## Test plan
- Load 0x11,0x22,0x33 with hold_cycles=0 and loop=0, then start → pat_out 0x11,0x22,0x33 on consecutive cycles; done one cycle after 0x33; count stays 3.
- hold_cycles=2, two entries 0xA5,0x5A → each word shown 3 cycles; pat_valid high for exactly 6 cycles.
- loop=1 with 0x01,0x02; stop asserted after 5 cycles → sequence 01,02,01,02,01; pat_valid=0 the cycle after stop; no done.
- Write 9 words with DEPTH=8 → wr_ready drops after the 8th word; count=8; the 9th word is not stored. clear+wr_valid in the same cycle → count=0.
- start with count=0, and start+stop together → remains IDLE, busy=0, no done.
- Reset asserted mid-PLAY with hold_cycles=3 → pat_out=0, pat_valid=0, busy=0 immediately; count=0 after reset. Separately, ena=0 for 4 cycles mid-word → the same word is held 4 extra cycles.
